// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the pipelined carry-lookahead adder.
// Holds the pipeline latency, the legal group sizes and the group-count helper.
package cla_pkg;

    localparam int CLA_LATENCY = 3;

    // Only 2-, 4- and 8-bit lookahead groups are supported.
    function automatic bit is_legal_group(input int group);
        case (group)
            2, 4, 8: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int num_groups(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// cla_group: combinational GROUP-bit lookahead cell.
// Ports: a_i/b_i operands, c_i group carry-in; p_o/g_o per-bit propagate and
// generate, c_o carry into each bit, pg_o/gg_o group propagate and generate.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_i,
    output logic [GROUP-1:0] p_o,
    output logic [GROUP-1:0] g_o,
    output logic [GROUP-1:0] c_o,
    output logic             pg_o,
    output logic             gg_o
);

    logic [GROUP:0] cy;
    logic           gg;

    always_comb begin
        p_o   = a_i ^ b_i;
        g_o   = a_i & b_i;
        cy    = '0;
        cy[0] = c_i;
        for (int i = 0; i < GROUP; i++) begin
            cy[i+1] = g_o[i] | (p_o[i] & cy[i]);
        end
        c_o  = cy[GROUP-1:0];
        pg_o = &p_o;
        // Group generate is the group carry-out with a zero carry-in.
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg = g_o[i] | (p_o[i] & gg);
        end
        gg_o = gg;
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: 3-stage elastic carry-lookahead adder, sum = a + b + c_in.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with a, b, c_in;
// out_valid/out_ready with sum, c_out and signed overflow.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NG = num_groups(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0 || !is_legal_group(GROUP)) begin : g_bad_params
        $error("pipelined_cla_adder: illegal WIDTH=%0d GROUP=%0d", WIDTH, GROUP);
    end

    // Handshake / stage occupancy
    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;

    // Stage 1
    logic [WIDTH-1:0] a1_q, b1_q;
    logic [WIDTH-1:0] p1_d, g1_d, p1_q, g1_q;
    logic [NG-1:0]    pg1_d, gg1_d, pg1_q, gg1_q;
    logic             cin1_q;
    logic [WIDTH-1:0] unused_s1_cy;
    logic             unused_ab;

    // Stage 2
    logic [NG:0]      c2_d, c2_q;
    logic [WIDTH-1:0] p2_q, g2_q;
    logic             am2_q, bm2_q;

    // Stage 3
    logic [WIDTH-1:0] p3, cy3, sum_d, sum_q;
    logic [WIDTH-1:0] unused_s3_g;
    logic [NG-1:0]    unused_s3_pg, unused_s3_gg;
    logic             ovf_d, cout_q, ovf_q;

    // A stage loads when it is empty or the stage after it advances.
    assign ld3      = ~v3_q | out_ready;
    assign ld2      = ~v2_q | ld3;
    assign ld1      = ~v1_q | ld2;
    assign in_ready = ld1;

    // Only the operand sign bits are needed past stage 1.
    assign unused_ab = ^{a1_q[WIDTH-2:0], b1_q[WIDTH-2:0]};

    for (genvar k = 0; k < NG; k++) begin : g_s1
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i  (a[k*GROUP +: GROUP]),
            .b_i  (b[k*GROUP +: GROUP]),
            .c_i  (1'b0),
            .p_o  (p1_d[k*GROUP +: GROUP]),
            .g_o  (g1_d[k*GROUP +: GROUP]),
            .c_o  (unused_s1_cy[k*GROUP +: GROUP]),
            .pg_o (pg1_d[k]),
            .gg_o (gg1_d[k])
        );
    end

    always_comb begin
        c2_d    = '0;
        c2_d[0] = cin1_q;
        for (int k = 0; k < NG; k++) begin
            c2_d[k+1] = gg1_q[k] | (pg1_q[k] & c2_d[k]);
        end
    end

    // p and g are never both set, so (p|g, g) is an operand pair with the
    // same per-bit propagate and generate as the original a, b.
    for (genvar k = 0; k < NG; k++) begin : g_s3
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i  (p2_q[k*GROUP +: GROUP] | g2_q[k*GROUP +: GROUP]),
            .b_i  (g2_q[k*GROUP +: GROUP]),
            .c_i  (c2_q[k]),
            .p_o  (p3[k*GROUP +: GROUP]),
            .g_o  (unused_s3_g[k*GROUP +: GROUP]),
            .c_o  (cy3[k*GROUP +: GROUP]),
            .pg_o (unused_s3_pg[k]),
            .gg_o (unused_s3_gg[k])
        );
    end

    assign sum_d = p3 ^ cy3;
    assign ovf_d = (am2_q == bm2_q) && (sum_d[WIDTH-1] != am2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            p1_q   <= '0;
            g1_q   <= '0;
            pg1_q  <= '0;
            gg1_q  <= '0;
            cin1_q <= 1'b0;
            c2_q   <= '0;
            p2_q   <= '0;
            g2_q   <= '0;
            am2_q  <= 1'b0;
            bm2_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (ld1) v1_q <= in_valid;
            if (ld2) v2_q <= v1_q;
            if (ld3) v3_q <= v2_q;
            if (ld1 && in_valid) begin
                a1_q   <= a;
                b1_q   <= b;
                p1_q   <= p1_d;
                g1_q   <= g1_d;
                pg1_q  <= pg1_d;
                gg1_q  <= gg1_d;
                cin1_q <= c_in;
            end
            if (ld2 && v1_q) begin
                c2_q  <= c2_d;
                p2_q  <= p1_q;
                g2_q  <= g1_q;
                am2_q <= a1_q[WIDTH-1];
                bm2_q <= b1_q[WIDTH-1];
            end
            if (ld3 && v2_q) begin
                sum_q  <= sum_d;
                cout_q <= c2_q[NG];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign c_out     = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and random checks of the pipelined adder
// at 16/4, 32/8 and 8/2 against an arithmetic reference with scoreboards.
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, c_in;
    logic [31:0] a_r, b_r;

    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        ir32, ov32, co32, of32;
    logic [31:0] s32;
    logic        ir8, ov8, co8, of8;
    logic [7:0]  s8;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    bit acc     = 1'b0;
    bit ir_seen = 1'b0;

    logic [33:0] q16[$];
    logic [33:0] q32[$];
    logic [33:0] q8[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .a(a_r[15:0]), .b(b_r[15:0]), .c_in(c_in), .out_valid(ov16),
        .out_ready(out_ready), .sum(s16), .c_out(co16), .overflow(of16)
    );
    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .a(a_r), .b(b_r), .c_in(c_in), .out_valid(ov32),
        .out_ready(out_ready), .sum(s32), .c_out(co32), .overflow(of32)
    );
    pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
        .a(a_r[7:0]), .b(b_r[7:0]), .c_in(c_in), .out_valid(ov8),
        .out_ready(out_ready), .sum(s8), .c_out(co8), .overflow(of8)
    );

    // Reference: {overflow, c_out, sum} of a w-bit add, sum zero-extended.
    function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci);
        longint unsigned m, t;
        logic [31:0] s;
        logic co, ov;
        m  = (longint'(1) << w) - 1;
        t  = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
        s  = 32'(t & m);
        co = t[w];
        ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample just after the negedge, score transfers, advance one cycle.
    task automatic step();
        #1;
        ir_seen = ir16;
        if (ov16 && out_ready) begin
            n_out++;
            if (q16.size() == 0) check("r16_unexpected", 64'(q16.size()), 64'd1);
            else check("r16", {30'b0, of16, co16, 16'b0, s16}, {30'b0, q16.pop_front()});
        end
        if (ov32 && out_ready) begin
            if (q32.size() == 0) check("r32_unexpected", 64'(q32.size()), 64'd1);
            else check("r32", {30'b0, of32, co32, s32}, {30'b0, q32.pop_front()});
        end
        if (ov8 && out_ready) begin
            if (q8.size() == 0) check("r8_unexpected", 64'(q8.size()), 64'd1);
            else check("r8", {30'b0, of8, co8, 24'b0, s8}, {30'b0, q8.pop_front()});
        end
        acc = in_valid && ir16;
        if (acc) begin
            q16.push_back(model(16, a_r, b_r, c_in));
            q32.push_back(model(32, a_r, b_r, c_in));
            q8.push_back(model(8, a_r, b_r, c_in));
        end
        @(negedge clk);
    endtask

    task automatic op_lat(input string tag, input logic [15:0] x,
                          input logic [15:0] y, input logic ci,
                          input logic [15:0] es, input logic eco,
                          input logic eov);
        bit seen;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_r       = {16'h0, x};
        b_r       = {16'h0, y};
        c_in      = ci;
        step();
        check({tag, "_acc"}, 64'(acc), 64'd1);
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int k = 1; k <= 6 && !seen; k++) begin
            if (ov16) begin
                seen = 1'b1;
                check({tag, "_lat"}, 64'(k), 64'(CLA_LATENCY));
                check({tag, "_sum"}, 64'(s16), 64'(es));
                check({tag, "_cout"}, 64'(co16), 64'(eco));
                check({tag, "_ovf"}, 64'(of16), 64'(eov));
            end
            step();
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, last, cnt, lows, j, n0, ops;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c_in      = 1'b0;
        a_r       = '0;
        b_r       = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(ov16), 64'd0);
        check("rst_sum", 64'(s16), 64'd0);
        check("rst_cout", 64'(co16), 64'd0);
        check("rst_ovf", 64'(of16), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full ripple and signed overflow
        op_lat("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_lat("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_lat("ovf_neg", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);

        // Streaming: 5 back-to-back ops
        first = -1; last = -1; cnt = 0; lows = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ov16) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            in_valid = (i < 5);
            a_r = $urandom;
            b_r = $urandom;
            c_in = 1'($urandom);
            step();
            if (i < 5 && !acc) lows++;
        end
        check("str_in_ready_low", 64'(lows), 64'd0);
        check("str_count", 64'(cnt), 64'd5);
        check("str_first", 64'(first), 64'd3);
        check("str_run", 64'(last - first), 64'd4);

        // Back-pressure: out_ready low for the first 4 cycles
        j = 0;
        n0 = n_out;
        for (int i = 0; i < 40 && (j < 6 || q16.size() > 0); i++) begin
            out_ready = (i >= 4);
            in_valid  = (j < 6);
            a_r  = 32'h0000_9000 + 32'(j) * 32'h0000_1357;
            b_r  = 32'h0000_F00F ^ (32'(j) << 4);
            c_in = 1'(j);
            step();
            if (acc) j++;
            if (i == 3) begin
                check("bp_in_ready_full", 64'(ir_seen), 64'd0);
                check("bp_buffered", 64'(j), 64'd3);
            end
            if (i == 4) check("bp_in_ready_flow", 64'(ir_seen), 64'd1);
        end
        check("bp_accepted", 64'(j), 64'd6);
        check("bp_results", 64'(n_out - n0), 64'd6);
        check("bp_drained", 64'(q16.size()), 64'd0);

        // Reset with two ops in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_r = 32'h0000_0F0F; b_r = 32'h0000_00F1; c_in = 1'b0;
        step();
        a_r = 32'h0000_ABCD; b_r = 32'h0000_1111; c_in = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("rmid_pre_valid", 64'(ov16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_out_valid", 64'(ov16), 64'd0);
        check("rmid_sum", 64'(s16), 64'd0);
        q16.delete();
        q32.delete();
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_lat("post_rst", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        // Random traffic with random back-pressure
        ops = 0;
        in_valid = 1'b0;
        acc = 1'b0;
        for (int cyc = 0; cyc < 40000 && ops < 10000; cyc++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a_r  = $urandom;
                b_r  = $urandom;
                c_in = 1'($urandom);
                if ($urandom_range(0, 7) == 0) b_r = ~a_r;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc) ops++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q16.size() > 0; i++) step();
        check("rnd_ops", 64'(ops), 64'd10000);
        check("rnd_q16_empty", 64'(q16.size()), 64'd0);
        check("rnd_q32_empty", 64'(q32.size()), 64'd0);
        check("rnd_q8_empty", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
